// File: rtl/axis_frame_ctrl.sv
// -----------------------------------------------------------------------------
// axis_frame_ctrl
//
// Framing controller between an AXI-Stream producer (model output FIFO) and a
// DMA S2MM slave. Beats pass through a one-entry hold stage and an output
// register. TLAST is generated by a runtime beat count, an idle timeout or a
// flush on disable, so the DMA always sees terminated transfers.
//
// Optional feature macro: AXIS_FRAME_CTRL_STATS_EN
//   defined   -> stat_frames / stat_timeouts are live 32-bit wrapping counters
//   undefined -> both stat ports are tied to 0 and no counters are built
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            accept new beats when 1; 1->0 flushes the held beat
//   cfg_frame_len     beats per frame (0 = unbounded)
//   cfg_timeout       idle cycles before a forced TLAST (0 = disabled)
//   s_axis_*          input stream (tvalid, tdata, tready)
//   m_axis_*          output stream (tvalid, tdata, tlast, tready)
//   frame_done        one-cycle pulse after a TLAST handshake on m_axis
//   beat_count        beats of the current frame moved to the output register
//   stat_frames       TLAST handshakes seen
//   stat_timeouts     frames terminated by the idle timeout
// -----------------------------------------------------------------------------
module axis_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int TO_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  frame_done,
  output logic [LEN_WIDTH-1:0]  beat_count,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_timeouts
);

  // IDLE: hold empty. FILL: hold full while enabled. DRAIN: hold full while
  // disabled, waiting for the output register to take the flushed beat.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    frame_done_q, frame_done_d;
  logic [LEN_WIDTH-1:0]    beat_count_q, beat_count_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [TO_WIDTH-1:0]     timer_q, timer_d;

  // Release decode
  logic                    hold_v;
  logic                    hold_v_next;
  logic                    out_free;
  logic [LEN_WIDTH-1:0]    len_m1;
  logic                    last_cnt;
  logic                    to_exp;
  logic                    can_rel;
  logic                    rel_flush, rel_cnt, rel_to, rel_push;
  logic                    rel_any, rel_last;
  logic                    load;

  // The hold-valid bit is carried by the state encoding.
  assign hold_v   = (state_q != ST_IDLE);
  assign out_free = !m_tvalid_q || m_axis_tready;
  assign len_m1   = len_q - LEN_WIDTH'(1);
  assign last_cnt = (len_q != '0) && (beat_count_q == len_m1);
  assign to_exp   = (cfg_timeout != '0) && (timer_q == cfg_timeout);
  assign can_rel  = hold_v && out_free;

  // Priority: flush > count > timeout > push.
  assign rel_flush = can_rel && !enable;
  assign rel_cnt   = can_rel && enable && last_cnt;
  assign rel_to    = can_rel && enable && !last_cnt && to_exp;
  assign rel_push  = can_rel && enable && !last_cnt && !to_exp && s_axis_tvalid;
  assign rel_any   = rel_flush || rel_cnt || rel_to || rel_push;
  assign rel_last  = rel_flush || rel_cnt || rel_to;

  // The hold stage refills in the same cycle it releases, except after a
  // timeout release where the held beat leaves alone.
  assign s_axis_tready = enable && (!hold_v || rel_push || rel_cnt);
  assign load          = s_axis_tready && s_axis_tvalid;
  assign hold_v_next   = load || (hold_v && !rel_any);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    beat_count_d = beat_count_q;
    len_d        = len_q;
    timer_d      = timer_q;
    frame_done_d = m_tvalid_q && m_axis_tready && m_tlast_q;

    if (hold_v_next) begin
      state_d = enable ? ST_FILL : ST_DRAIN;
    end else begin
      state_d = ST_IDLE;
    end

    if (load) begin
      hold_data_d = s_axis_tdata;
    end

    // Output register: take a released beat, otherwise retire on handshake.
    if (rel_any) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = hold_data_q;
      m_tlast_d  = rel_last;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end

    // Beat counter. A disable with nothing held abandons an unterminated
    // frame; the count restarts without emitting anything.
    if (rel_any) begin
      beat_count_d = rel_last ? '0 : beat_count_q + LEN_WIDTH'(1);
    end else if (!enable && !hold_v && (beat_count_q != '0)) begin
      beat_count_d = '0;
    end

    // Latch the frame length only for the first beat of a frame; the
    // refill after a TLAST release also qualifies since the count resets.
    if (load && (beat_count_d == '0)) begin
      len_d = cfg_frame_len;
    end

    // Idle timer: restarts per loaded beat, runs while the held beat waits
    // for input (even when the output is blocked), saturates at all-ones.
    if (load || !hold_v_next) begin
      timer_d = '0;
    end else if (hold_v && !s_axis_tvalid && !last_cnt && (timer_q != '1)) begin
      timer_d = timer_q + TO_WIDTH'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_data_q  <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      frame_done_q <= 1'b0;
      beat_count_q <= '0;
      len_q        <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      frame_done_q <= frame_done_d;
      beat_count_q <= beat_count_d;
      len_q        <= len_d;
      timer_q      <= timer_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign frame_done    = frame_done_q;
  assign beat_count    = beat_count_q;

`ifdef AXIS_FRAME_CTRL_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_timeouts_q, stat_timeouts_d;

  always_comb begin
    stat_frames_d   = stat_frames_q;
    stat_timeouts_d = stat_timeouts_q;
    if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
      stat_frames_d = stat_frames_q + 32'd1;
    end
    if (rel_to) begin
      stat_timeouts_d = stat_timeouts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q   <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_frames_q   <= stat_frames_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_frames   = stat_frames_q;
  assign stat_timeouts = stat_timeouts_q;
`else
  assign stat_frames   = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_axis_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_ctrl
//
// Scoreboard bench for axis_frame_ctrl. Stimulus tasks push the expected
// {tlast, tdata} of each issued beat; a monitor on the falling edge pops and
// compares on every m_axis handshake, checks frame_done timing and output
// stability under backpressure.
// -----------------------------------------------------------------------------
module tb_axis_frame_ctrl;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] cfg_frame_len = '0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          frame_done;
  logic [LW-1:0] beat_count;
  logic [31:0]   stat_frames;
  logic [31:0]   stat_timeouts;

  axis_frame_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TO_WIDTH(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_frame_len (cfg_frame_len),
    .cfg_timeout   (cfg_timeout),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_done    (frame_done),
    .beat_count    (beat_count),
    .stat_frames   (stat_frames),
    .stat_timeouts (stat_timeouts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    fd_cnt = 0;
  int    last_out_cyc = 0;
  int    acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, frame_done timing, stall stability.
  initial begin : monitor
    beat_t e;
    beat_t prev_out;
    logic  fd_exp;
    logic  stall_prev;
    fd_exp     = 1'b0;
    stall_prev = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fd_exp     = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (frame_done || fd_exp) check("frame_done_timing", frame_done, fd_exp);
        if (frame_done) fd_cnt++;
        if (stall_prev) begin
          check("stall_valid", m_axis_tvalid, 1);
          check("stall_data", m_axis_tdata, prev_out.data);
          check("stall_last", m_axis_tlast, prev_out.last);
        end
        fd_exp     = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_beat: got data=0x%0h last=%0b, required no beat",
                     m_axis_tdata, m_axis_tlast);
          end else begin
            e = sb.pop_front();
            check("out_data", m_axis_tdata, e.data);
            check("out_last", m_axis_tlast, e.last);
            if (m_axis_tlast) last_out_cyc = cyc;
          end
        end
      end
    end
  end

  // Issue one beat, record its expected output, wait for acceptance.
  task automatic send(input logic [DW-1:0] d, input logic last_exp);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    sb.push_back({last_exp, d});
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL send_accept: got no s_axis_tready for data 0x%0h, required acceptance", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    s_axis_tvalid = 1'b0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a1, a8, fd0;
    // Reset state
    rst_n = 1'b0;
    #2;
    check("rst_async_tvalid", m_axis_tvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_stat_frames", stat_frames, 0);
    check("rst_stat_timeouts", stat_timeouts, 0);
    check("rst_tready_disabled", s_axis_tready, 0);
    enable = 1'b1;
    #1;
    check("rst_tready_enabled", s_axis_tready, 1);
    @(posedge clk);
    #1;

    // Count framing: len 4, back-to-back 0x01..0x08
    cfg_frame_len = 16'd4;
    cfg_timeout   = 16'd0;
    fd0 = fd_cnt;
    a1 = 0;
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), (i % 4) == 0);
      if (i == 1) a1 = acc_cyc;
    end
    a8 = acc_cyc;
    wait_drain("cnt_drain");
    check("cnt_throughput", a8 - a1, 7);
    check("cnt_last_latency", last_out_cyc - a8, 1);
    check("cnt_frames", fd_cnt - fd0, 2);
    check("cnt_beat_count", beat_count, 0);

    // Timeout: len 16, timeout 10
    cfg_frame_len = 16'd16;
    cfg_timeout   = 16'd10;
    fd0 = fd_cnt;
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b1);
    a8 = acc_cyc;
    wait_drain("to_drain");
    check("to_latency", last_out_cyc - a8, 11);
    check("to_frames", fd_cnt - fd0, 1);
    check("to_beat_count", beat_count, 0);

    // Backpressure: output stalled 5 cycles mid-frame
    cfg_frame_len = 16'd4;
    cfg_timeout   = 16'd0;
    fd0 = fd_cnt;
    send(8'h21, 1'b0);
    m_axis_tready = 1'b0;
    fork
      begin
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_s_tready_low", s_axis_tready, 0);
        check("bp_out_valid", m_axis_tvalid, 1);
        check("bp_out_data", m_axis_tdata, 8'h21);
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_frames", fd_cnt - fd0, 1);

    // Flush: 3 of 8 beats, then disable
    cfg_frame_len = 16'd8;
    fd0 = fd_cnt;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b1);
    enable        = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_s_tready", s_axis_tready, 0);
    end
    wait_drain("flush_drain");
    check("flush_frames", fd_cnt - fd0, 1);
    check("flush_beat_count", beat_count, 0);
    enable = 1'b1;

    // Unbounded frame: len 0, timeout 5, 20 beats
    cfg_frame_len = 16'd0;
    cfg_timeout   = 16'd5;
    fd0 = fd_cnt;
    for (int i = 0; i < 20; i++) begin
      send(8'h41 + DW'(i), i == 19);
    end
    a8 = acc_cyc;
    wait_drain("unb_drain");
    check("unb_frames", fd_cnt - fd0, 1);
    check("unb_latency", last_out_cyc - a8, 6);
`ifdef AXIS_FRAME_CTRL_STATS_EN
    check("stat_frames", stat_frames, 6);
    check("stat_timeouts", stat_timeouts, 2);
`else
    check("stat_frames_off", stat_frames, 0);
    check("stat_timeouts_off", stat_timeouts, 0);
`endif

    // Reset mid-frame: 2 of 4 beats, then reset
    cfg_frame_len = 16'd4;
    cfg_timeout   = 16'd0;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    s_axis_tvalid = 1'b0;
    #1;
    check("mid_pre_valid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_beat_count", beat_count, 0);
    check("mid_rst_stat_frames", stat_frames, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fd0 = fd_cnt;
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    send(8'h74, 1'b1);
    wait_drain("mid_drain");
    check("mid_frames", fd_cnt - fd0, 1);
    check("mid_beat_count", beat_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
